// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period, high time and rounded duty (tenths) of an
// asynchronous PWM input. A 4-step restoring divider produces the duty value.
`timescale 1ns/1ps
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [3:0]       duty_tenths,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic             overrun
);

  localparam int unsigned      NumW       = CNT_W + 5;
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StDiv} state_e;

  state_e           state_q, state_d;
  logic             meta_q, s_q, s_dly_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [NumW-1:0]  rem_q, rem_d;
  logic [3:0]       quo_q, quo_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [3:0]       duty_q, duty_d;
  logic             mv_q, mv_d;
  logic             to_q, to_d;
  logic             stuck_q, stuck_d;
  logic             ovr_q, ovr_d;

  logic             rise;
  logic [NumW-1:0]  num;
  logic [NumW-1:0]  trial;
  logic [NumW-1:0]  rem_sub;
  logic             ge;
  logic [3:0]       quo_next;

  assign rise     = s_q & ~s_dly_q;
  // 10*H + floor(P/2): the half-divisor bias makes the truncating divide round half up
  assign num      = (NumW'(hi_cnt_q) << 3) + (NumW'(hi_cnt_q) << 1) + NumW'(per_cnt_q >> 1);
  assign trial    = NumW'(p_q) << step_q;
  assign ge       = (rem_q >= trial);
  assign rem_sub  = rem_q - trial;
  assign quo_next = {quo_q[2:0], ge};

  // Next-state: counters, arming, capture, divider steps, output updates, timeout
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    armed_d   = armed_q;
    p_d       = p_q;
    h_d       = h_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    step_d    = step_q;
    period_d  = period_q;
    high_d    = high_q;
    duty_d    = duty_q;
    mv_d      = 1'b0;
    to_d      = to_q;
    stuck_d   = stuck_q;
    ovr_d     = ovr_q;

    if (rise) begin
      per_cnt_d = CNT_W'(1);
      hi_cnt_d  = CNT_W'(1);
    end else begin
      if (per_cnt_q != TimeoutVal) per_cnt_d = per_cnt_q + CNT_W'(1);
      if (s_q && (hi_cnt_q != TimeoutVal)) hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: ;
      StDiv: begin
        rem_d  = ge ? rem_sub : rem_q;
        quo_d  = quo_next;
        step_d = step_q - 2'd1;
        if (step_q == 2'd0) begin
          state_d  = StIdle;
          period_d = p_q;
          high_d   = h_q;
          duty_d   = quo_next;
          mv_d     = 1'b1;
          to_d     = 1'b0;
          ovr_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Overrun set is evaluated after the divider so it wins over the clear on meas_valid
    if (rise) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (state_q == StIdle) begin
        p_d     = per_cnt_q;
        h_d     = hi_cnt_q;
        rem_d   = num;
        quo_d   = 4'd0;
        step_d  = 2'd3;
        state_d = StDiv;
      end else begin
        ovr_d = 1'b1;
      end
    end else if ((per_cnt_q != TimeoutVal) && (per_cnt_d == TimeoutVal)) begin
      // Fires once on entering saturation; a rise on the same cycle takes precedence
      to_d     = 1'b1;
      stuck_d  = s_q;
      duty_d   = s_q ? 4'd10 : 4'd0;
      period_d = '0;
      high_d   = '0;
      armed_d  = 1'b0;
    end
  end

  // State registers including the two-flop synchroniser and edge-detect delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      meta_q    <= 1'b0;
      s_q       <= 1'b0;
      s_dly_q   <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      armed_q   <= 1'b0;
      p_q       <= '0;
      h_q       <= '0;
      rem_q     <= '0;
      quo_q     <= 4'd0;
      step_q    <= 2'd0;
      period_q  <= '0;
      high_q    <= '0;
      duty_q    <= 4'd0;
      mv_q      <= 1'b0;
      to_q      <= 1'b0;
      stuck_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= pwm_in;
      s_q       <= meta_q;
      s_dly_q   <= s_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      armed_q   <= armed_d;
      p_q       <= p_d;
      h_q       <= h_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      step_q    <= step_d;
      period_q  <= period_d;
      high_q    <= high_d;
      duty_q    <= duty_d;
      mv_q      <= mv_d;
      to_q      <= to_d;
      stuck_q   <= stuck_d;
      ovr_q     <= ovr_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign duty_tenths = duty_q;
  assign meas_valid  = mv_q;
  assign timeout     = to_q;
  assign stuck_level = stuck_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter with hand-computed expectations.
`timescale 1ns/1ps
module tb_pwm_duty_meter;

  localparam int unsigned CntW = 16;
  localparam int unsigned Tmo  = 60;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pwm_in;
  logic [CntW-1:0] period;
  logic [CntW-1:0] high_time;
  logic [3:0]      duty_tenths;
  logic            meas_valid;
  logic            timeout;
  logic            stuck_level;
  logic            overrun;

  pwm_duty_meter #(
    .CNT_W   (CntW),
    .TIMEOUT (Tmo)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .duty_tenths (duty_tenths),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .stuck_level (stuck_level),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int              cyc       = 0;
  int              n_vec     = 0;
  int              n_err     = 0;
  int              last_rise = 0;
  int              mv_cnt    = 0;
  int              mv_cyc    = 0;
  logic [CntW-1:0] mv_per    = '0;
  logic [CntW-1:0] mv_hi     = '0;
  logic [3:0]      mv_duty   = '0;
  logic            mv_ovr    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle meas_valid is high together with the values it presents
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mv_cnt  <= mv_cnt + 1;
      mv_cyc  <= cyc;
      mv_per  <= period;
      mv_hi   <= high_time;
      mv_duty <= duty_tenths;
      mv_ovr  <= overrun;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after clock edge number e
  task automatic to_edge(input int e);
    repeat (e - cyc) @(posedge clk);
    #1;
  endtask

  // n periods of hi cycles high then lo cycles low, at a random phase to clk
  task automatic drive(input int hi, input int lo, input int n);
    int ph;
    ph = int'($urandom_range(8, 2));
    @(posedge clk);
    #ph;
    for (int i = 0; i < n; i++) begin
      pwm_in    = 1'b1;
      last_rise = cyc;
      repeat (hi) @(posedge clk);
      #ph;
      pwm_in = 1'b0;
      repeat (lo) @(posedge clk);
      #ph;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_duty", 32'(duty_tenths), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_stuck", 32'(stuck_level), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // 50% duty, period 10: first rise arms only, five captures follow
    drive(5, 5, 6);
    check("p10_count", 32'(mv_cnt), 5);
    check("p10_period", 32'(mv_per), 10);
    check("p10_high", 32'(mv_hi), 5);
    check("p10_duty", 32'(mv_duty), 5);
    check("p10_overrun", 32'(mv_ovr), 0);
    check("p10_latency", 32'(mv_cyc), 32'(last_rise + 7));

    // High-time sweep at period 10
    for (int h = 1; h <= 9; h++) begin
      drive(h, 10 - h, 3);
      check("sweep_duty", 32'(mv_duty), 32'(h));
      check("sweep_high", 32'(mv_hi), 32'(h));
    end

    drive(7, 13, 3);
    check("p20h7_period", 32'(mv_per), 20);
    check("p20h7_duty", 32'(mv_duty), 4);
    drive(6, 14, 3);
    check("p20h6_duty", 32'(mv_duty), 3);

    // Held high: timeout exactly Tmo cycles after the rise is recognised
    @(posedge clk);
    #3;
    pwm_in = 1'b1;
    k      = cyc;
    to_edge(k + 61);
    check("hi_tmo_early", 32'(timeout), 0);
    to_edge(k + 62);
    check("hi_tmo", 32'(timeout), 1);
    check("hi_tmo_stuck", 32'(stuck_level), 1);
    check("hi_tmo_duty", 32'(duty_tenths), 10);
    check("hi_tmo_period", 32'(period), 0);
    check("hi_tmo_high", 32'(high_time), 0);
    pwm_in = 1'b0;

    // Resume at 30%: first rise only re-arms, timeout clears on a capture
    base = mv_cnt;
    drive(3, 7, 1);
    check("rearm_tmo", 32'(timeout), 1);
    check("rearm_nocap", 32'(mv_cnt), 32'(base));
    drive(3, 7, 2);
    check("resume_tmo", 32'(timeout), 0);
    check("resume_duty", 32'(mv_duty), 3);
    check("resume_period", 32'(mv_per), 10);

    // Held low after the last rise
    to_edge(last_rise + 61);
    check("lo_tmo_early", 32'(timeout), 0);
    to_edge(last_rise + 62);
    check("lo_tmo", 32'(timeout), 1);
    check("lo_tmo_stuck", 32'(stuck_level), 0);
    check("lo_tmo_duty", 32'(duty_tenths), 0);
    check("lo_tmo_period", 32'(period), 0);

    // Period 4 is below the minimum: every other rise lands while the divider is busy
    drive(2, 2, 7);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_period", 32'(mv_per), 4);
    check("ovr_duty", 32'(mv_duty), 5);
    drive(5, 5, 3);
    check("ovr_clear", 32'(overrun), 0);
    check("ovr_mv_flag", 32'(mv_ovr), 0);
    check("ovr_p10_period", 32'(mv_per), 10);
    check("ovr_p10_high", 32'(mv_hi), 5);

    // Reset pulse during cycle C+2 of a divide
    base = mv_cnt;
    @(posedge clk);
    #3;
    pwm_in = 1'b1;
    k      = cyc;
    to_edge(k + 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", 32'(period), 0);
    check("mid_rst_high", 32'(high_time), 0);
    check("mid_rst_duty", 32'(duty_tenths), 0);
    check("mid_rst_valid", 32'(meas_valid), 0);
    check("mid_rst_timeout", 32'(timeout), 0);
    check("mid_rst_stuck", 32'(stuck_level), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    to_edge(k + 5);
    rst_n = 1'b1;
    to_edge(k + 17);
    check("mid_rst_no_mv", 32'(mv_cnt), 32'(base));
    check("mid_rst_period2", 32'(period), 0);
    pwm_in = 1'b0;
    drive(4, 6, 2);
    check("post_rst_count", 32'(mv_cnt), 32'(base + 2));
    check("post_rst_period", 32'(mv_per), 10);
    check("post_rst_duty", 32'(mv_duty), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
